// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   NOP           : canonical no-op (addi x0,x0,0) shown when the buffer is empty
//   fetch_state_e : RUN (responses are kept) / DRAIN (stale responses dropped)
//   fetch_entry_t : one buffered instruction with its PC
package fetch_pkg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {RUN, DRAIN} fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO holding fetched {pc, instr} entries.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push, din    : write din at the tail
//   pop          : drop the head (caller only pops when count>0)
//   flush        : empty the FIFO; wins over a same-cycle push
//   count        : number of valid entries (0..DEPTH)
//   head         : entry at the read pointer (meaningless when count==0)
module prefetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push,
   input  fetch_entry_t  din,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage carries no reset; count gates its visibility.
   always_ff @(posedge clk_i) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch stage with a DEPTH-entry prefetch buffer.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   redirect_i/_pc_i    : taken branch from EX; flushes and restarts fetch
//   imem_req_o/addr_o   : in-order word-aligned requests to instruction memory
//   imem_gnt_i          : request accepted this cycle
//   imem_rvalid_i/rdata : in-order responses (variable latency)
//   instr_vld_o/rdy_i   : valid/ready handshake towards decode
//   instr_o, pc_o       : buffer head (NOP / 0 when empty)
// Credit: buffered + outstanding never exceeds DEPTH, so every response has
// a free slot. After a redirect, every response still in flight is stale and
// is counted off by the discard counter (DRAIN state).
module if_prefetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_vld_o,
   input  logic        instr_rdy_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc, resp_pc, tgt;
   logic [CW-1:0] outstanding, discard, count, outst_nxt, discard_nxt;
   fetch_state_e  state;
   fetch_entry_t  head;
   logic          credit, fire, rv_ok, push, pop;

   assign tgt    = redirect_pc_i & ~32'h3;
   assign credit = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);

   assign imem_req_o  = !rst_i && credit;
   assign imem_addr_o = fetch_pc;
   assign fire        = imem_req_o && imem_gnt_i;

   // A response with nothing outstanding belongs to a pre-reset request.
   assign rv_ok = imem_rvalid_i && (outstanding != '0);
   assign push  = rv_ok && (state == RUN) && !redirect_i;
   assign pop   = instr_vld_o && instr_rdy_i;

   assign outst_nxt = outstanding + CW'(fire) - CW'(rv_ok);

   // On redirect everything in flight after the edge is stale, which is
   // exactly the next outstanding count.
   always_comb begin
      discard_nxt = discard;
      if (redirect_i)                    discard_nxt = outst_nxt;
      else if (rv_ok && state == DRAIN)  discard_nxt = discard - CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         state       <= RUN;
      end else begin
         outstanding <= outst_nxt;
         discard     <= discard_nxt;
         state       <= (discard_nxt != '0) ? DRAIN : RUN;
         if (redirect_i) begin
            fetch_pc <= tgt;
            resp_pc  <= tgt;
         end else begin
            if (fire) fetch_pc <= fetch_pc + 32'd4;
            if (push) resp_pc  <= resp_pc + 32'd4;
         end
      end
   end

   prefetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .din   ('{pc: resp_pc, instr: imem_rdata_i}),
      .pop   (pop),
      .flush (redirect_i),
      .count (count),
      .head  (head)
   );

   assign instr_vld_o = (count != '0);
   assign instr_o     = instr_vld_o ? head.instr : NOP;
   assign pc_o        = instr_vld_o ? head.pc    : 32'h0;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(imem_rvalid_i && outstanding == '0))
            else $error("imem response with no request outstanding");
         assert (({1'b0, count} + {1'b0, outstanding}) <= (CW+1)'(DEPTH))
            else $error("buffered + outstanding exceeds DEPTH");
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;
   import fetch_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst, redirect, gnt, rvalid, rdy;
   logic [31:0] redirect_pc, rdata;
   logic        req, vld;
   logic [31:0] addr, instr, pc;

   always #5 clk = ~clk;

   if_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .instr_vld_o(vld), .instr_rdy_i(rdy), .instr_o(instr), .pc_o(pc)
   );

   typedef struct { logic [31:0] a; int due; } mreq_t;
   typedef struct {
      logic rdy, gnt, red; logic [31:0] rpc;
      logic e_req; logic [31:0] e_addr; logic e_vld; logic [31:0] e_pc;
   } vec_t;

   mreq_t        pend[$];   // memory model: granted requests awaiting response
   fetch_entry_t expq[$];   // scoreboard: entries decode should see, in order
   int           lat = 1, cyc = 0, errors = 0, checks = 0;
   logic [31:0]  exp_fetch = RESET_PC;
   logic         s_req, s_vld;
   logic [31:0]  s_addr, s_pc, s_instr;
   vec_t         tbl[10];

   function automatic logic [31:0] word(input logic [31:0] a);
      return ~a ^ 32'h1234_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, sample at +1,
   // update memory model and scoreboard, then advance to the next falling edge.
   task automatic step(input logic r_rdy, input logic r_gnt, input logic r_red,
                       input logic [31:0] r_pc);
      fetch_entry_t e;
      rdy = r_rdy; gnt = r_gnt; redirect = r_red; redirect_pc = r_pc;
      rvalid = (pend.size() > 0) && (pend[0].due <= cyc);
      rdata  = rvalid ? word(pend[0].a) : 32'h0;
      #1;
      s_req = req; s_addr = addr; s_vld = vld; s_pc = pc; s_instr = instr;
      if (rvalid) void'(pend.pop_front());
      if (s_req && gnt) pend.push_back('{s_addr, cyc + lat});
      if (rst) begin
         expq.delete();
         exp_fetch = RESET_PC;
      end else begin
         if (s_vld && rdy) begin
            if (expq.size() == 0) begin
               checks++; errors++;
               $display("FAIL pop_unexpected: got pc %h, expected nothing", s_pc);
            end else begin
               e = expq.pop_front();
               chk("pop_pc", s_pc, e.pc);
               chk("pop_instr", s_instr, e.instr);
            end
         end
         if (s_req) chk("fetch_addr", s_addr, exp_fetch);
         if (s_req && gnt) begin
            if (!r_red) expq.push_back('{pc: exp_fetch, instr: word(exp_fetch)});
            exp_fetch += 32'd4;
         end
         if (r_red) begin
            expq.delete();
            exp_fetch = {r_pc[31:2], 2'b00};
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step(1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
   endtask

   task automatic wait_first(input string name, input logic [31:0] exp_pc, input int gnt_mode);
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1, (gnt_mode == 0) || (i % 3 != 1), 1'b0, 32'h0);
         if (s_vld) begin
            found = 1;
            chk({name, "_pc"}, s_pc, exp_pc);
            chk({name, "_instr"}, s_instr, word(exp_pc));
         end
      end
      if (!found) begin
         checks++; errors++;
         $display("FAIL %s_timeout: no valid instruction within 20 cycles", name);
      end
   endtask

   initial begin
      int n;
      //             rdy  gnt  red  rpc          req  addr         vld  pc
      tbl[0] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h000,1'b0,32'h000};
      tbl[1] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h004,1'b0,32'h000};
      tbl[2] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h008,1'b1,32'h000};
      tbl[3] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h00C,1'b1,32'h004};
      tbl[4] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h010,1'b1,32'h008};
      tbl[5] = '{1'b1,1'b1,1'b1,32'h203,   1'b1,32'h014,1'b1,32'h00C};
      tbl[6] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h200,1'b0,32'h000};
      tbl[7] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h204,1'b0,32'h000};
      tbl[8] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h208,1'b1,32'h200};
      tbl[9] = '{1'b1,1'b1,1'b0,32'h0,     1'b1,32'h20C,1'b1,32'h204};

      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; gnt = 1'b0;
      rvalid = 1'b0; rdata = 32'h0; rdy = 1'b0;
      @(negedge clk);

      // Reset state, then 1-cycle memory streaming and a redirect to 0x203.
      do_reset(4);
      chk("rst_req", {31'h0, s_req}, 32'h0);
      chk("rst_vld", {31'h0, s_vld}, 32'h0);
      chk("rst_instr", s_instr, NOP);
      chk("rst_pc", s_pc, 32'h0);
      lat = 1;
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].rdy, tbl[i].gnt, tbl[i].red, tbl[i].rpc);
         chk($sformatf("vec%0d_req", i), {31'h0, s_req}, {31'h0, tbl[i].e_req});
         if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].e_addr);
         chk($sformatf("vec%0d_vld", i), {31'h0, s_vld}, {31'h0, tbl[i].e_vld});
         chk($sformatf("vec%0d_pc", i), s_pc, tbl[i].e_pc);
         chk($sformatf("vec%0d_instr", i), s_instr, tbl[i].e_vld ? word(tbl[i].e_pc) : NOP);
      end

      // Credit limit: decode stalled, exactly DEPTH requests go out.
      do_reset(4);
      lat = 1; n = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         if (s_req) n++;
      end
      chk("credit_reqs", n, DEPTH);
      chk("credit_stall", {31'h0, s_req}, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("credit_pop_vld", {31'h0, s_vld}, 32'h1);
      chk("credit_pop_pc", s_pc, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("credit_resume_req", {31'h0, s_req}, 32'h1);
      chk("credit_resume_addr", s_addr, 32'h10);
      repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

      // 3-cycle memory: redirect with two requests in flight, gnt gaps.
      do_reset(4);
      lat = 3;
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h100);
      wait_first("lat3_redirect", 32'h100, 1);
      repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect with same-cycle grant and response, then back-to-back.
      do_reset(4);
      lat = 2;
      repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h300);
      step(1'b1, 1'b1, 1'b1, 32'h400);
      chk("b2b_vld_flushed", {31'h0, s_vld}, 32'h0);
      wait_first("b2b_redirect", 32'h400, 0);
      repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Reset with two buffered and two in flight; late responses ignored.
      do_reset(4);
      lat = 3;
      repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("pre_rst_vld", {31'h0, s_vld}, 32'h1);
      do_reset(2);
      chk("midrst_req", {31'h0, s_req}, 32'h0);
      chk("midrst_vld", {31'h0, s_vld}, 32'h0);
      chk("midrst_instr", s_instr, NOP);
      chk("midrst_pc", s_pc, 32'h0);
      wait_first("after_rst", RESET_PC, 0);
      repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
